muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative, parametrised RV32M multiply/divide unit for the RISC-V pipeline, sitting beside the single-cycle ALU in the execute stage. It accepts one operation through a valid/ready handshake and computes it over multiple cycles with a shift-add multiplier or restoring divider. It then holds the result until the consumer accepts it. Division by zero and signed overflow are detected up front and complete early.

## Interface
- `XLEN`, 32: operand/result width; must be ≥ 4.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `flush` input 1: abort any in-flight operation (pipeline kill).
- `in_valid` input 1: operation presented.
- `in_ready` output 1: unit can accept an operation; high only in IDLE.
- `funct3` input 3: RV32M op; 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `a` input XLEN: rs1 operand.
- `b` input XLEN: rs2 operand.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer takes result.
- `result` output XLEN: result; stable while `out_valid` is high.
- `busy` output 1: high in every state except IDLE.

## Operation
- States: IDLE, RUN, FIXUP, DONE.
- **IDLE.** On `in_valid && in_ready`, latch `funct3`, the sign flags, and the magnitudes of `a`/`b`.
  - A signed operand is negative when its MSB is set and the op treats it as signed.
  - Signed treatment: MULH a,b; MULHSU a only; DIV/REM a,b.
  - Next state is RUN, except for the fast paths below, which go straight to DONE.
- **Fast paths** (div ops only):
  - `b == 0`: DIV/DIVU give all-ones; REM/REMU give `a`.
  - DIV/REM with `a == 2^(XLEN-1)` and `b == -1`: DIV gives `a`; REM gives 0.
- **RUN.** Runs exactly XLEN iterations using an iteration counter of clog2(XLEN)+1 bits.
  - Multiply: unsigned shift-add on magnitudes into a 2·XLEN product register.
  - Divide: restoring divide on magnitudes, giving an XLEN quotient and XLEN remainder.
  - After the last iteration, go to FIXUP.
- **FIXUP.** One cycle.
  - Product is negated if the two operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Output select: MUL takes product[XLEN-1:0]; MULH/MULHSU/MULHU take product[2·XLEN-1:XLEN]; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Next state is DONE.
- **DONE.** `out_valid` is high and `result` is held. On `out_ready`, go to IDLE.
- **flush:** from any state, the next state is IDLE.
  - `out_valid` drops the next cycle and no result is delivered.
  - `flush` takes priority over `in_valid` and `out_ready` in the same cycle.
  - An operation presented in the flush cycle is not accepted.
- **reset:** state is IDLE. Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0, counter=0.
  - Reset mid-operation discards the operation with no output.
- `funct3` and the operands are sampled only at acceptance. Input changes afterwards have no effect.

## Timing
- Acceptance edge is T. Normal path: `out_valid` is first high in cycle T+XLEN+2 (XLEN RUN cycles plus one FIXUP cycle). That is cycle 34 for XLEN=32.
- Fast path: `out_valid` is high in cycle T+1.
- `in_ready` falls in cycle T+1 and rises in the cycle after the output handshake. There is no overlap of consecutive operations.
- Minimum issue interval: XLEN+3 cycles for the normal path, 2 cycles for the fast path.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Structure
- Add `FNC_MUL`…`FNC_REMU` (funct3 values) and `OPC_ARI_RTYPE`'s M-extension `funct7` (0000001) to the shared opcode header.
- State encodings are local to the module.
- One sub-module, `muldiv_step`: combinational single-iteration datapath.
  - Multiply: conditional add and shift.
  - Divide: trial subtract and restore.
  - Parametrised by XLEN and instantiated once.

## Test plan
All cases use XLEN=32.
- MUL a=7, b=0xFFFFFFFD (-3) → result 0xFFFFFFEB; `out_valid` at T+34; `in_ready` low over T+1..T+34.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=-7, b=2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 7/2 → 3; REMU 7/2 → 1.
- Fast paths, each with `out_valid` at T+1:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Backpressure: hold `out_ready` low for 5 cycles in DONE → `result` stable, `busy`=1, and an `in_valid` offered in that window is not accepted.
- Abort: assert `flush` in RUN cycle 10 → `out_valid` never rises and `in_ready`=1 next cycle. Repeat with `reset` in FIXUP → all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M opcode constants and operand-signedness decode for the
// multiply/divide unit.
package muldiv_unit_pkg;

  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] FN7_MULDIV    = 7'b0000001;

  localparam logic [2:0] FNC_MUL    = 3'd0;
  localparam logic [2:0] FNC_MULH   = 3'd1;
  localparam logic [2:0] FNC_MULHSU = 3'd2;
  localparam logic [2:0] FNC_MULHU  = 3'd3;
  localparam logic [2:0] FNC_DIV    = 3'd4;
  localparam logic [2:0] FNC_DIVU   = 3'd5;
  localparam logic [2:0] FNC_REM    = 3'd6;
  localparam logic [2:0] FNC_REMU   = 3'd7;

  function automatic logic op_signed_a(input logic [2:0] f3);
    return (f3 == FNC_MULH) || (f3 == FNC_MULHSU) || (f3 == FNC_DIV) || (f3 == FNC_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] f3);
    return (f3 == FNC_MULH) || (f3 == FNC_DIV) || (f3 == FNC_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response handshake bundle between the execute stage and muldiv_unit.
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, funct3, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, funct3, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit_step.sv
// One iteration of the shared accumulator: shift-add multiply or
// restoring divide, both operating on unsigned magnitudes.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              i_is_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_operand,
  output logic [2*XLEN-1:0] o_acc
);
  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_rem_sh;
  logic [XLEN:0] w_diff;

  assign w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_operand};
  assign w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
  assign w_diff   = w_rem_sh - {1'b0, i_operand};

  // Divide keeps {remainder, dividend/quotient}; multiply keeps {partial, multiplier}.
  always_comb begin
    o_acc = {1'b0, i_acc[2*XLEN-1:1]};
    if (i_is_div) begin
      if (!w_diff[XLEN]) o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
      else               o_acc = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
    end else if (i_acc[0]) begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: accepts one op, iterates XLEN
// cycles, sign-fixes, then holds the result until the consumer takes it.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_unit_if.slave bus
);
  import muldiv_unit_pkg::*;

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP, S_DONE} state_e;

  state_e            r_state, w_state_next;
  logic [2:0]        r_op;
  logic              r_neg_a, r_neg_b;
  logic [XLEN-1:0]   r_mag_b;
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_result;

  logic              w_accept, w_neg_a, w_neg_b, w_div_zero, w_div_ovf, w_fast, w_last;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_fast_result, w_quot, w_rem, w_fix_result;
  logic [2*XLEN-1:0] w_step_acc, w_prod;

  assign w_accept   = (r_state == S_IDLE) && bus.in_valid && !bus.flush;
  assign w_neg_a    = bus.a[XLEN-1] && op_signed_a(bus.funct3);
  assign w_neg_b    = bus.b[XLEN-1] && op_signed_b(bus.funct3);
  assign w_mag_a    = w_neg_a ? -bus.a : bus.a;
  assign w_mag_b    = w_neg_b ? -bus.b : bus.b;
  assign w_div_zero = bus.funct3[2] && (bus.b == '0);
  assign w_div_ovf  = ((bus.funct3 == FNC_DIV) || (bus.funct3 == FNC_REM)) &&
                      (bus.a == SMIN) && (bus.b == '1);
  assign w_fast     = w_div_zero || w_div_ovf;
  assign w_last     = (r_cnt == CW'(XLEN - 1));

  // funct3[1] separates REM/REMU from DIV/DIVU among the divide ops.
  always_comb begin
    w_fast_result = '0;
    if (w_div_zero)     w_fast_result = bus.funct3[1] ? bus.a : '1;
    else if (w_div_ovf) w_fast_result = bus.funct3[1] ? '0 : bus.a;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_is_div  (r_op[2]),
    .i_acc     (r_acc),
    .i_operand (r_mag_b),
    .o_acc     (w_step_acc)
  );

  assign w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
  assign w_quot = (r_neg_a ^ r_neg_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    case (r_op)
      FNC_MUL:                       w_fix_result = w_prod[XLEN-1:0];
      FNC_MULH, FNC_MULHSU, FNC_MULHU: w_fix_result = w_prod[2*XLEN-1:XLEN];
      FNC_DIV, FNC_DIVU:             w_fix_result = w_quot;
      default:                       w_fix_result = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.flush) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_next = w_fast ? S_DONE : S_RUN;
        S_RUN:   if (w_last) w_state_next = S_FIXUP;
        S_FIXUP: w_state_next = S_DONE;
        S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.busy      = (r_state != S_IDLE);
    bus.out_valid = (r_state == S_DONE);
    bus.result    = r_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= bus.funct3;
        r_neg_a <= w_neg_a;
        r_neg_b <= w_neg_b;
        r_mag_b <= w_mag_b;
        r_acc   <= {{XLEN{1'b0}}, w_mag_a};
        r_cnt   <= '0;
        if (w_fast) r_result <= w_fast_result;
      end
      if (r_state == S_RUN) begin
        r_acc <= w_step_acc;
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == S_FIXUP && !bus.flush) r_result <= w_fix_result;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: reference model built on 64-bit
// integer arithmetic, plus latency, backpressure, flush and reset cases.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(XLEN)) bus();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, p;
    longint unsigned up;
    logic ovf;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sbv; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sbv; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
  endfunction

  task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int w;
    @(negedge clk);
    bus.funct3 = f3; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
    if (!bus.in_ready) chk("accept_wait", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    exp_q.push_back(model(f3, a, b));
    #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.funct3 = 3'($urandom);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int hold);
    int lat;
    logic rdy_seen;
    logic [31:0] want, held;
    present(f3, a, b);
    lat = 1;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
    chk("in_ready_busy", {31'b0, rdy_seen | bus.in_ready}, 32'd0);
    chk("latency", 32'(lat), 32'(exp_latency(f3, a, b)));
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk("result", bus.result, want);
    held = bus.result;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1; bus.funct3 = 3'd0; bus.a = $urandom; bus.b = $urandom;
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("hold_result", bus.result, held);
      chk("hold_busy", {31'b0, bus.busy}, 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("post_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("post_ready", {31'b0, bus.in_ready}, 32'd1);
    $display("op f3=%0d a=%h b=%h result=%h expected=%h lat=%0d hold=%0d", f3, a, b, held, want, lat, hold);
  endtask

  // kind 0 = flush, kind 1 = reset, asserted during cycle T+at_lat.
  task automatic abort_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int kind, input int at_lat);
    int lat;
    logic seen;
    present(f3, a, b);
    lat = 1;
    while (lat < at_lat) begin @(posedge clk); #1; lat++; end
    if (kind == 0) bus.flush = 1'b1; else reset = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; reset = 1'b0; bus.in_valid = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    chk("abort_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("abort_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    if (kind == 1) chk("abort_result", bus.result, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort_no_output", {31'b0, seen}, 32'd0);
    $display("abort kind=%0s f3=%0d a=%h b=%h at_cycle=%0d", (kind == 0) ? "flush" : "reset", f3, a, b, at_lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.funct3 = 3'd0;
    bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    reset = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd5, 32'd7, 32'd2, 0);
    run_op(3'd7, 32'd7, 32'd2, 0);
    run_op(3'd4, 32'd5, 32'd0, 0);
    run_op(3'd7, 32'd5, 32'd0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd1, 32'h1234_5678, 32'hFEDC_BA98, 5);

    for (int i = 0; i < 8; i++) begin
      rf3 = 3'(i);
      ra = $urandom;
      rb = (i == 6) ? 32'd0 : $urandom;
      run_op(rf3, ra, rb, 0);
    end

    // flush together with in_valid in IDLE must not start an operation
    @(negedge clk);
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    chk("flush_blocks_accept", {31'b0, bus.busy}, 32'd0);

    abort_op(3'd0, 32'd123, 32'd456, 0, 10);
    run_op(3'd5, 32'd100, 32'd7, 0);
    abort_op(3'd4, 32'hFFFF_FF00, 32'd3, 1, XLEN + 1);
    run_op(3'd0, 32'd9, 32'd9, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
